// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback arbiter: source indices and the per-source holding slot.
package wb_arb_pkg;
   localparam int NSRC = 3;
   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_FPU = 2'd1;
   localparam logic [1:0] SRC_MEM = 2'd2;
   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 5;

   typedef struct packed {
      logic                 full;
      logic                 fp;
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wb_slot_t;
endpackage

// File: rtl/wb_rr_arb.sv
// 3-way request -> one-hot grant. WB_RR_EN selects round-robin (pointer) over fixed MEM>FPU>ALU.
module wb_rr_arb
   import wb_arb_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] req,
   input  logic            upd,
   output logic [NSRC-1:0] gnt
);
`ifdef WB_RR_EN
   logic [1:0] ptr_q, ptr_d, win;
   logic [1:0] idx;

   // Walk from the farthest offset back to the pointer so the nearest requester wins.
   always_comb begin
      gnt = '0;
      win = ptr_q;
      idx = ptr_q;
      for (int i = NSRC - 1; i >= 0; i--) begin
         idx = 2'((int'(ptr_q) + i) % NSRC);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            win      = idx;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (upd) ptr_d = (win == SRC_MEM) ? SRC_ALU : win + 2'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= SRC_ALU;
      else       ptr_q <= ptr_d;
   end
`else
   logic unused_ok;
   assign unused_ok = &{1'b0, clk, reset, upd};

   always_comb begin
      gnt = '0;
      if (req[SRC_MEM])      gnt[SRC_MEM] = 1'b1;
      else if (req[SRC_FPU]) gnt[SRC_FPU] = 1'b1;
      else if (req[SRC_ALU]) gnt[SRC_ALU] = 1'b1;
   end
`endif
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU/FPU/MEM 1-entry slots drained onto int and FP register-file write ports.
// Define WB_RR_EN for round-robin arbitration; default is fixed priority MEM > FPU > ALU.
module wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic              alu_fp,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              fpu_valid,
   output logic              fpu_ready,
   input  logic              fpu_fp,
   input  logic [ADDR_W-1:0] fpu_rd,
   input  logic [DATA_W-1:0] fpu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic              mem_fp,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              int_we,
   output logic [ADDR_W-1:0] int_waddr,
   output logic [DATA_W-1:0] int_wdata,
   output logic              fp_we,
   output logic [ADDR_W-1:0] fp_waddr,
   output logic [DATA_W-1:0] fp_wdata,
   output logic              wb_busy
);
   logic [NSRC-1:0]             src_v, src_fp, rdy, full_v;
   logic [NSRC-1:0][ADDR_W-1:0] src_rd;
   logic [NSRC-1:0][DATA_W-1:0] src_data;
   logic [NSRC-1:0]             int_req, fp_req, int_gnt, fp_gnt;
   wb_slot_t [NSRC-1:0]         slot_q, slot_d;
   wb_slot_t                    int_win, fp_win;
   logic                        int_upd, fp_upd;
   logic                        int_we_q, int_we_d, fp_we_q, fp_we_d;
   logic [ADDR_W-1:0]           int_waddr_q, int_waddr_d, fp_waddr_q, fp_waddr_d;
   logic [DATA_W-1:0]           int_wdata_q, int_wdata_d, fp_wdata_q, fp_wdata_d;

   assign src_v    = {mem_valid, fpu_valid, alu_valid};
   assign src_fp   = {mem_fp, fpu_fp, alu_fp};
   assign src_rd   = {mem_rd, fpu_rd, alu_rd};
   assign src_data = {mem_data, fpu_data, alu_data};

   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         full_v[i]  = slot_q[i].full;
         int_req[i] = slot_q[i].full & ~slot_q[i].fp;
         fp_req[i]  = slot_q[i].full & slot_q[i].fp;
      end
   end

   wb_rr_arb u_int_arb (.clk(clk), .reset(reset), .req(int_req), .upd(int_upd), .gnt(int_gnt));
   wb_rr_arb u_fp_arb  (.clk(clk), .reset(reset), .req(fp_req),  .upd(fp_upd),  .gnt(fp_gnt));

   always_comb begin
      int_win = '0;
      fp_win  = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (int_gnt[i]) int_win = slot_q[i];
         if (fp_gnt[i])  fp_win  = slot_q[i];
      end
   end

   // Int r0 is hardwired: the slot drains, but neither the port nor the RR pointer sees it.
   assign int_upd = (|int_gnt) & (int_win.rd != '0);
   assign fp_upd  = |fp_gnt;

   always_comb begin
      int_we_d    = int_upd;
      int_waddr_d = int_upd ? ADDR_W'(int_win.rd)   : int_waddr_q;
      int_wdata_d = int_upd ? DATA_W'(int_win.data) : int_wdata_q;
      fp_we_d     = fp_upd;
      fp_waddr_d  = fp_upd ? ADDR_W'(fp_win.rd)     : fp_waddr_q;
      fp_wdata_d  = fp_upd ? DATA_W'(fp_win.data)   : fp_wdata_q;
   end

   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         rdy[i]    = ~slot_q[i].full | int_gnt[i] | fp_gnt[i];
         slot_d[i] = slot_q[i];
         if (int_gnt[i] | fp_gnt[i]) slot_d[i].full = 1'b0;
         if (src_v[i] & rdy[i]) begin
            slot_d[i].full = 1'b1;
            slot_d[i].fp   = src_fp[i];
            slot_d[i].rd   = WB_ADDR_W'(src_rd[i]);
            slot_d[i].data = WB_DATA_W'(src_data[i]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q      <= '0;
         int_we_q    <= 1'b0;
         int_waddr_q <= '0;
         int_wdata_q <= '0;
         fp_we_q     <= 1'b0;
         fp_waddr_q  <= '0;
         fp_wdata_q  <= '0;
      end else begin
         slot_q      <= slot_d;
         int_we_q    <= int_we_d;
         int_waddr_q <= int_waddr_d;
         int_wdata_q <= int_wdata_d;
         fp_we_q     <= fp_we_d;
         fp_waddr_q  <= fp_waddr_d;
         fp_wdata_q  <= fp_wdata_d;
      end
   end

   assign alu_ready = rdy[SRC_ALU];
   assign fpu_ready = rdy[SRC_FPU];
   assign mem_ready = rdy[SRC_MEM];
   assign int_we    = int_we_q;
   assign int_waddr = int_waddr_q;
   assign int_wdata = int_wdata_q;
   assign fp_we     = fp_we_q;
   assign fp_waddr  = fp_waddr_q;
   assign fp_wdata  = fp_wdata_q;
   assign wb_busy   = |full_v;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected writes with their cycle, a monitor checks them.
module tb_wb_arbiter;
   logic        clk = 1'b0, reset = 1'b1;
   logic        alu_valid, alu_fp, fpu_valid, fpu_fp, mem_valid, mem_fp;
   logic        alu_ready, fpu_ready, mem_ready;
   logic [4:0]  alu_rd, fpu_rd, mem_rd;
   logic [31:0] alu_data, fpu_data, mem_data;
   logic        int_we, fp_we, wb_busy;
   logic [4:0]  int_waddr, fp_waddr;
   logic [31:0] int_wdata, fp_wdata;

   wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_fp(alu_fp), .alu_rd(alu_rd), .alu_data(alu_data),
      .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_fp(fpu_fp), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_fp(mem_fp), .mem_rd(mem_rd), .mem_data(mem_data),
      .int_we(int_we), .int_waddr(int_waddr), .int_wdata(int_wdata),
      .fp_we(fp_we), .fp_waddr(fp_waddr), .fp_wdata(fp_wdata), .wb_busy(wb_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      int          c;
   } exp_t;
   exp_t int_q[$], fp_q[$];
   exp_t mi, mf;
   logic [4:0]  int_la, fp_la;
   logic [31:0] int_ld, fp_ld;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_int(input logic [4:0] a, input logic [31:0] d, input int dly);
      int_q.push_back('{a: a, d: d, c: cyc + dly});
   endtask

   task automatic exp_fp(input logic [4:0] a, input logic [31:0] d, input int dly);
      fp_q.push_back('{a: a, d: d, c: cyc + dly});
   endtask

   task automatic idle();
      alu_valid = 0; fpu_valid = 0; mem_valid = 0;
   endtask

   // Monitor: every write must match the head of its queue, including the cycle it lands in.
   always @(negedge clk) begin
      if (reset) begin
         int_la = '0; int_ld = '0; fp_la = '0; fp_ld = '0;
      end else begin
         if (int_we) begin
            if (int_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL int_unexpected: got write addr %0h data %0h, expected none (cycle %0d)", int_waddr, int_wdata, cyc);
            end else begin
               mi = int_q.pop_front();
               chk("int_waddr", int_waddr, mi.a);
               chk("int_wdata", int_wdata, mi.d);
               chk("int_cycle", cyc, mi.c);
               int_la = mi.a; int_ld = mi.d;
            end
         end else begin
            chk("int_waddr_hold", int_waddr, int_la);
            chk("int_wdata_hold", int_wdata, int_ld);
         end
         if (fp_we) begin
            if (fp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL fp_unexpected: got write addr %0h data %0h, expected none (cycle %0d)", fp_waddr, fp_wdata, cyc);
            end else begin
               mf = fp_q.pop_front();
               chk("fp_waddr", fp_waddr, mf.a);
               chk("fp_wdata", fp_wdata, mf.d);
               chk("fp_cycle", cyc, mf.c);
               fp_la = mf.a; fp_ld = mf.d;
            end
         end else begin
            chk("fp_waddr_hold", fp_waddr, fp_la);
            chk("fp_wdata_hold", fp_wdata, fp_ld);
         end
      end
   end

   initial begin
      idle();
      alu_fp = 0; fpu_fp = 0; mem_fp = 0;
      alu_rd = 0; fpu_rd = 0; mem_rd = 0;
      alu_data = 0; fpu_data = 0; mem_data = 0;
      repeat (2) step();
      chk("rst_int_we", int_we, 0);
      chk("rst_fp_we", fp_we, 0);
      chk("rst_int_waddr", int_waddr, 0);
      chk("rst_int_wdata", int_wdata, 0);
      chk("rst_fp_waddr", fp_waddr, 0);
      chk("rst_fp_wdata", fp_wdata, 0);
      chk("rst_busy", wb_busy, 0);
      chk("rst_ready", {alu_ready, fpu_ready, mem_ready}, 3'b111);
      reset = 0;
      step();

      // single uncontended ALU int write
      alu_valid = 1; alu_fp = 0; alu_rd = 5; alu_data = 32'h1234;
      exp_int(5, 32'h1234, 2);
      step(); idle();
      chk("t1_alu_ready", alu_ready, 1);
      chk("t1_busy", wb_busy, 1);
      repeat (3) step();

      // int and FP writes in the same cycle
      alu_valid = 1; alu_fp = 0; alu_rd = 3; alu_data = 32'hAAAA_0001;
      fpu_valid = 1; fpu_fp = 1; fpu_rd = 3; fpu_data = 32'hBBBB_0002;
      exp_int(3, 32'hAAAA_0001, 2);
      exp_fp(3, 32'hBBBB_0002, 2);
      step(); idle();
      repeat (3) step();

      // fresh pointers, then three-way int contention
      reset = 1; step(); reset = 0; step();
      alu_valid = 1; alu_fp = 0; alu_rd = 7; alu_data = 32'h0000_0a10;
      fpu_valid = 1; fpu_fp = 0; fpu_rd = 8; fpu_data = 32'h0000_0f20;
      mem_valid = 1; mem_fp = 0; mem_rd = 9; mem_data = 32'h0000_0e30;
`ifdef WB_RR_EN
      exp_int(7, 32'h0a10, 2); exp_int(8, 32'h0f20, 3); exp_int(9, 32'h0e30, 4);
      step(); idle();
      chk("t3_ready_a", {alu_ready, fpu_ready, mem_ready}, 3'b100);
      step();
      chk("t3_ready_b", {alu_ready, fpu_ready, mem_ready}, 3'b110);
`else
      exp_int(9, 32'h0e30, 2); exp_int(8, 32'h0f20, 3); exp_int(7, 32'h0a10, 4);
      step(); idle();
      chk("t3_ready_a", {alu_ready, fpu_ready, mem_ready}, 3'b001);
      step();
      chk("t3_ready_b", {alu_ready, fpu_ready, mem_ready}, 3'b011);
`endif
      repeat (4) step();

      // FPU int write parks the RR pointer on MEM; MEM r0 must not move it
      fpu_valid = 1; fpu_fp = 0; fpu_rd = 11; fpu_data = 32'h0000_1111;
      exp_int(11, 32'h1111, 2);
      step(); idle();
      repeat (2) step();
      mem_valid = 1; mem_fp = 0; mem_rd = 0; mem_data = 32'h0000_FFFF;
      step(); idle();
      chk("t4_mem_ready", mem_ready, 1);
      step();
      chk("t4_mem_ready2", mem_ready, 1);
      chk("t4_busy", wb_busy, 0);
      alu_valid = 1; alu_fp = 0; alu_rd = 12; alu_data = 32'h0000_C0C0;
      mem_valid = 1; mem_fp = 0; mem_rd = 13; mem_data = 32'h0000_D0D0;
      exp_int(13, 32'hD0D0, 2); exp_int(12, 32'hC0C0, 3);
      step(); idle();
      repeat (4) step();

      // streaming ALU: one write per cycle, ready never drops
      for (int i = 0; i < 5; i++) begin
         alu_valid = 1; alu_fp = 0; alu_rd = 5'(16 + i); alu_data = 32'hA000 + i;
         chk("t5_alu_ready", alu_ready, 1);
         exp_int(5'(16 + i), 32'hA000 + i, 2);
         step();
      end
      idle();
      repeat (3) step();

      // reset with all slots full discards everything
      alu_valid = 1; alu_fp = 0; alu_rd = 1; alu_data = 32'hDEAD_0001;
      fpu_valid = 1; fpu_fp = 1; fpu_rd = 2; fpu_data = 32'hDEAD_0002;
      mem_valid = 1; mem_fp = 0; mem_rd = 4; mem_data = 32'hDEAD_0004;
      step(); idle();
      chk("t6_busy_full", wb_busy, 1);
      reset = 1;
      #1;
      chk("t6_busy_rst", wb_busy, 0);
      chk("t6_int_we_rst", int_we, 0);
      chk("t6_fp_we_rst", fp_we, 0);
      step();
      reset = 0;
      repeat (4) step();
      chk("t6_busy_after", wb_busy, 0);

      chk("int_q_drained", int_q.size(), 0);
      chk("fp_q_drained", fp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
